// File: rtl/pll_phase_slave_if.sv
// Avalon-MM slave bus plus ALTPLL dynamic phase-shift handshake, bundled for pll_phase_slave.
interface pll_phase_slave_if #(
    parameter int unsigned ADDRESS_WIDTH = 5
) ();
    logic [ADDRESS_WIDTH-1:0] avs_s0_address;
    logic [3:0]               avs_s0_byteenable;
    logic                     avs_s0_read;
    logic                     avs_s0_write;
    logic [31:0]              avs_s0_writedata;
    logic [31:0]              avs_s0_readdata;
    logic                     avs_s0_waitrequest;
    logic [3:0]               pll_phasecounterselect;
    logic                     pll_phaseupdown;
    logic                     pll_phasestep;
    logic                     pll_phasedone;

    modport master (
        output avs_s0_address, avs_s0_byteenable, avs_s0_read, avs_s0_write, avs_s0_writedata,
        output pll_phasedone,
        input  avs_s0_readdata, avs_s0_waitrequest,
        input  pll_phasecounterselect, pll_phaseupdown, pll_phasestep
    );

    modport slave (
        input  avs_s0_address, avs_s0_byteenable, avs_s0_read, avs_s0_write, avs_s0_writedata,
        input  pll_phasedone,
        output avs_s0_readdata, avs_s0_waitrequest,
        output pll_phasecounterselect, pll_phaseupdown, pll_phasestep
    );
endinterface

// File: rtl/pll_phase_slave.sv
// Avalon-MM control/status slave that turns register writes into ALTPLL phasestep sequences,
// tracking the phasedone handshake with per-wait timeouts.
module pll_phase_slave #(
    parameter int unsigned ADDRESS_WIDTH     = 5,
    parameter int unsigned STEP_PULSE_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 255,
    parameter logic [31:0] ID_VALUE          = 32'h504C_4C31
) (
    input logic              csi_slave_clk_clk,
    input logic              csi_slave_clk_reset_n,
    pll_phase_slave_if.slave bus_io
);
    typedef enum logic [2:0] {StIdle, StPulse, StWaitLow, StWaitHigh, StNext} state_e;

    localparam logic [3:0] PulseLast   = 4'(STEP_PULSE_CYCLES - 1);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  pulse_cnt_q, pulse_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  remaining_q, remaining_d;
    logic        work_updown_q, work_updown_d;
    logic [3:0]  work_sel_q, work_sel_d;
    logic        ctrl_updown_q, ctrl_updown_d;
    logic [3:0]  ctrl_sel_q, ctrl_sel_d;
    logic [7:0]  steps_q, steps_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        rd_ack_q, rd_ack_d;
    logic [31:0] readdata_q, readdata_d;

    logic        busy;
    logic        addr_ctrl, addr_steps, addr_status, addr_id;
    logic        rd_start, wr_req, wr_stall, wr_acc, wr_b0, start;
    logic [31:0] wdata, rd_mux;
    logic        unused_bits;

    assign wdata       = bus_io.avs_s0_writedata;
    assign unused_bits = ^{bus_io.avs_s0_byteenable[3:1], wdata[31:8]};
    assign busy        = (state_q != StIdle);

    assign addr_ctrl   = (bus_io.avs_s0_address == ADDRESS_WIDTH'(0));
    assign addr_steps  = (bus_io.avs_s0_address == ADDRESS_WIDTH'(1));
    assign addr_status = (bus_io.avs_s0_address == ADDRESS_WIDTH'(2));
    assign addr_id     = (bus_io.avs_s0_address == ADDRESS_WIDTH'(3));

    // Read wins over a simultaneous write; CTRL/STEPS writes are held off while a sequence runs.
    assign rd_start = bus_io.avs_s0_read && !rd_ack_q;
    assign wr_req   = bus_io.avs_s0_write && !bus_io.avs_s0_read;
    assign wr_stall = wr_req && busy && (addr_ctrl || addr_steps);
    assign wr_acc   = wr_req && !wr_stall;
    assign wr_b0    = wr_acc && bus_io.avs_s0_byteenable[0];
    assign start    = wr_b0 && addr_ctrl && wdata[0];

    always_comb begin
        rd_mux = '0;
        if (addr_ctrl) begin
            rd_mux = {24'h0, ctrl_sel_q, 2'b00, ctrl_updown_q, 1'b0};
        end else if (addr_steps) begin
            rd_mux = {24'h0, steps_q};
        end else if (addr_status) begin
            rd_mux = {16'h0, remaining_q, 5'h0, error_q, done_q, busy};
        end else if (addr_id) begin
            rd_mux = ID_VALUE;
        end
    end

    always_comb begin
        state_d       = state_q;
        pulse_cnt_d   = pulse_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        remaining_d   = remaining_q;
        work_updown_d = work_updown_q;
        work_sel_d    = work_sel_q;
        ctrl_updown_d = ctrl_updown_q;
        ctrl_sel_d    = ctrl_sel_q;
        steps_d       = steps_q;
        done_d        = done_q;
        error_d       = error_q;
        rd_ack_d      = rd_start;
        readdata_d    = rd_start ? rd_mux : readdata_q;

        if (wr_b0) begin
            if (addr_ctrl) begin
                ctrl_updown_d = wdata[1];
                ctrl_sel_d    = wdata[7:4];
            end
            if (addr_steps) begin
                steps_d = wdata[7:0];
            end
            if (addr_status) begin
                if (wdata[1]) done_d  = 1'b0;
                if (wdata[2]) error_d = 1'b0;
            end
        end

        // Flag sets below come after the W1C clears so a same-cycle set wins.
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_updown_d = wdata[1];
                    work_sel_d    = wdata[7:4];
                    remaining_d   = steps_q;
                    error_d       = 1'b0;
                    done_d        = (steps_q == 8'd0);
                    pulse_cnt_d   = 4'd0;
                    if (steps_q != 8'd0) state_d = StPulse;
                end
            end
            StPulse: begin
                if (pulse_cnt_q == PulseLast) begin
                    state_d   = StWaitLow;
                    tmo_cnt_d = 8'd0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 4'd1;
                end
            end
            StWaitLow: begin
                if (!bus_io.pll_phasedone) begin
                    state_d   = StWaitHigh;
                    tmo_cnt_d = 8'd0;
                end else if (tmo_cnt_q == TimeoutLast) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            StWaitHigh: begin
                if (bus_io.pll_phasedone) begin
                    remaining_d = remaining_q - 8'd1;
                    state_d     = StNext;
                end else if (tmo_cnt_q == TimeoutLast) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            StNext: begin
                pulse_cnt_d = 4'd0;
                if (remaining_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StPulse;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge csi_slave_clk_clk) begin
        if (!csi_slave_clk_reset_n) begin
            state_q       <= StIdle;
            pulse_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            remaining_q   <= '0;
            work_updown_q <= 1'b0;
            work_sel_q    <= '0;
            ctrl_updown_q <= 1'b0;
            ctrl_sel_q    <= '0;
            steps_q       <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            rd_ack_q      <= 1'b0;
            readdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            pulse_cnt_q   <= pulse_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            remaining_q   <= remaining_d;
            work_updown_q <= work_updown_d;
            work_sel_q    <= work_sel_d;
            ctrl_updown_q <= ctrl_updown_d;
            ctrl_sel_q    <= ctrl_sel_d;
            steps_q       <= steps_d;
            done_q        <= done_d;
            error_q       <= error_d;
            rd_ack_q      <= rd_ack_d;
            readdata_q    <= readdata_d;
        end
    end

    assign bus_io.avs_s0_readdata        = readdata_q;
    assign bus_io.avs_s0_waitrequest     = !csi_slave_clk_reset_n || rd_start || wr_stall;
    assign bus_io.pll_phasestep          = (state_q == StPulse);
    assign bus_io.pll_phasecounterselect = work_sel_q;
    assign bus_io.pll_phaseupdown        = work_updown_q;
endmodule

// File: tb/tb_pll_phase_slave.sv
// Randomized bench for pll_phase_slave: PLL handshake model, register-file reference model
// and pulse monitor.
module tb_pll_phase_slave;
    localparam int unsigned AW        = 5;
    localparam int unsigned PulseCyc  = 2;
    localparam int unsigned TmoCyc    = 255;
    localparam logic [31:0] IdVal     = 32'h504C_4C31;
    localparam int          BusLimit  = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_phase_slave_if #(.ADDRESS_WIDTH(AW)) bus ();

    pll_phase_slave #(
        .ADDRESS_WIDTH(AW), .STEP_PULSE_CYCLES(PulseCyc), .TIMEOUT_CYCLES(TmoCyc), .ID_VALUE(IdVal)
    ) dut (
        .csi_slave_clk_clk    (clk),
        .csi_slave_clk_reset_n(rst_n),
        .bus_io               (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference register state.
    logic [3:0] m_sel;
    logic       m_ud;
    logic [7:0] m_steps, m_rem;
    logic       m_done, m_err;

    // PLL model: 0 normal, 1 ignore steps (phasedone stuck high), 2 drop but never raise.
    int pll_mode = 0;
    int drop_dly = 2;
    int rise_dly = 4;
    int run_len  = 0;
    int widths[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_reg(input logic [4:0] a);
        case (a)
            5'd0:    return {24'h0, m_sel, 2'b00, m_ud, 1'b0};
            5'd1:    return {24'h0, m_steps};
            5'd2:    return {16'h0, m_rem, 5'h0, m_err, m_done, 1'b0};
            5'd3:    return IdVal;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_sel = '0; m_ud = 1'b0; m_steps = '0; m_rem = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] be, output int waits);
        @(negedge clk);
        bus.avs_s0_address   = addr;
        bus.avs_s0_byteenable = be;
        bus.avs_s0_writedata = data;
        bus.avs_s0_write     = 1'b1;
        #1;
        waits = 0;
        while (bus.avs_s0_waitrequest && waits < BusLimit) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= BusLimit) check_eq("bus_write_bound", 32'(waits), 32'h0);
        @(posedge clk); #1;
        bus.avs_s0_write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] addr, output logic [31:0] data, output int waits);
        @(negedge clk);
        bus.avs_s0_address = addr;
        bus.avs_s0_read    = 1'b1;
        #1;
        waits = 0;
        while (bus.avs_s0_waitrequest && waits < BusLimit) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= BusLimit) check_eq("bus_read_bound", 32'(waits), 32'h0);
        data = bus.avs_s0_readdata;
        @(posedge clk); #1;
        bus.avs_s0_read = 1'b0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        int w;
        for (int i = 0; i < 500; i++) begin
            bus_read(5'd2, st, w);
            if (!st[0]) break;
        end
        if (st[0]) check_eq("idle_bound", 32'(st[0]), 32'h0);
    endtask

    task automatic start_seq(input logic [7:0] steps, input logic ud, input logic [3:0] sel);
        logic [31:0] r;
        int w;
        r = $urandom;
        r[7:0] = steps;
        bus_write(5'd1, r, 4'hF, w);
        m_steps = steps;
        widths.delete();
        r = $urandom;
        r[7:4] = sel;
        r[1:0] = {ud, 1'b1};
        bus_write(5'd0, r, 4'h1 | 4'($urandom), w);
        m_sel = sel;
        m_ud  = ud;
        m_err = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic run_seq(input logic [7:0] steps, input logic ud, input logic [3:0] sel,
                           input int drop, input int rise);
        logic [31:0] st, d;
        int w;
        pll_mode = 0; drop_dly = drop; rise_dly = rise;
        start_seq(steps, ud, sel);
        check_eq("start_lat", 32'(bus.pll_phasestep), 32'(steps != 8'd0));
        if (steps != 8'd0) begin
            check_eq("sel_out", 32'(bus.pll_phasecounterselect), 32'(sel));
            check_eq("ud_out", 32'(bus.pll_phaseupdown), 32'(ud));
        end
        wait_idle(st);
        m_done = 1'b1; m_rem = 8'd0;
        check_eq("seq_status", st, exp_reg(5'd2));
        check_eq("pulse_count", 32'(widths.size()), 32'(steps));
        foreach (widths[i]) check_eq("pulse_width", 32'(widths[i]), 32'(PulseCyc));
        if (steps != 8'd0) begin
            check_eq("sel_hold", 32'(bus.pll_phasecounterselect), 32'(sel));
            check_eq("ud_hold", 32'(bus.pll_phaseupdown), 32'(ud));
        end
        bus_read(5'd0, d, w);
        check_eq("ctrl_rd", d, exp_reg(5'd0));
    endtask

    // PLL model, driven on the falling edge.
    initial begin
        bus.pll_phasedone = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.pll_phasestep && pll_mode != 1) begin
                while (bus.pll_phasestep) @(negedge clk);
                repeat (drop_dly - 1) @(negedge clk);
                bus.pll_phasedone = 1'b0;
                if (pll_mode == 2) wait (pll_mode != 2);
                else repeat (rise_dly) @(negedge clk);
                bus.pll_phasedone = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.pll_phasestep) run_len++;
        else if (run_len > 0) begin
            widths.push_back(run_len);
            run_len = 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, r;
        logic [4:0]  a, ra;
        logic [3:0]  be;
        int w;

        bus.avs_s0_address = '0; bus.avs_s0_byteenable = '0; bus.avs_s0_writedata = '0;
        bus.avs_s0_read = 1'b0; bus.avs_s0_write = 1'b0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_waitreq", 32'(bus.avs_s0_waitrequest), 32'h1);
        check_eq("rst_rdata", bus.avs_s0_readdata, 32'h0);
        check_eq("rst_step", 32'(bus.pll_phasestep), 32'h0);
        check_eq("rst_sel", 32'(bus.pll_phasecounterselect), 32'h0);
        check_eq("rst_ud", 32'(bus.pll_phaseupdown), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check_eq("rst_rel_waitreq", 32'(bus.avs_s0_waitrequest), 32'h0);

        bus_read(5'd3, d, w);
        check_eq("id_value", d, IdVal);
        check_eq("id_waits", 32'(w), 32'h1);
        bus_read(5'd7, d, w);
        check_eq("addr7", d, 32'h0);
        bus_read(5'd2, d, w);
        check_eq("status_rst", d, exp_reg(5'd2));

        run_seq(8'd3, 1'b1, 4'd5, 2, 4);
        run_seq(8'd0, 1'b0, 4'd9, 2, 4);
        bus_write(5'd2, 32'h2, 4'h1, w);
        m_done = 1'b0;
        bus_read(5'd2, d, w);
        check_eq("w1c_done", d, exp_reg(5'd2));

        for (int i = 0; i < 6; i++) begin
            run_seq(8'($urandom_range(0, 5)), 1'($urandom), 4'($urandom),
                    $urandom_range(1, 4), $urandom_range(1, 5));
        end

        // WAIT_LOW timeout; a stalled STEPS write measures how long the sequence stays busy.
        pll_mode = 1;
        start_seq(8'd2, 1'b1, 4'd5);
        bus_write(5'd1, 32'h7, 4'h1, w);
        check_eq("timeout_cycles", 32'(w), 32'(PulseCyc + TmoCyc));
        m_steps = 8'd7; m_err = 1'b1; m_rem = 8'd2;
        bus_read(5'd2, d, w);
        check_eq("tmo_status", d, exp_reg(5'd2));
        check_eq("tmo_status_lit", d, 32'h0204);
        check_eq("tmo_pulses", 32'(widths.size()), 32'h1);
        bus_read(5'd1, d, w);
        check_eq("stalled_steps", d, exp_reg(5'd1));
        bus_write(5'd2, 32'h4, 4'hE, w);
        bus_read(5'd2, d, w);
        check_eq("w1c_no_be0", d, exp_reg(5'd2));
        bus_write(5'd2, 32'h4, 4'h1, w);
        m_err = 1'b0;
        bus_read(5'd2, d, w);
        check_eq("w1c_err", d, 32'h0200);
        pll_mode = 0;

        // WAIT_HIGH timeout: remaining never decrements.
        pll_mode = 2; drop_dly = 2;
        r = 32'($urandom_range(1, 4));
        start_seq(r[7:0], 1'b0, 4'd3);
        wait_idle(d);
        m_err = 1'b1; m_rem = r[7:0];
        check_eq("tmo_hi_status", d, exp_reg(5'd2));
        pll_mode = 0;
        repeat (5) @(posedge clk);
        bus_write(5'd2, 32'h6, 4'h1, w);
        m_err = 1'b0;

        // Writes while busy: STATUS passes, STEPS is held.
        pll_mode = 0; drop_dly = 2; rise_dly = 4;
        start_seq(8'd2, 1'b1, 4'd6);
        bus_write(5'd2, 32'h6, 4'h1, w);
        check_eq("status_no_stall", 32'(w), 32'h0);
        bus_write(5'd1, 32'h5A, 4'hF, w);
        check_eq("steps_stalled", 32'(w > 0), 32'h1);
        m_steps = 8'h5A; m_done = 1'b1; m_rem = 8'd0;
        bus_read(5'd1, d, w);
        check_eq("steps_after_stall", d, exp_reg(5'd1));
        bus_read(5'd2, d, w);
        check_eq("status_after_stall", d, exp_reg(5'd2));

        // Random register traffic against the reference model.
        for (int i = 0; i < 14; i++) begin
            a  = 5'($urandom_range(0, 31));
            be = 4'($urandom);
            d  = $urandom;
            if (a == 5'd0) d[0] = 1'b0;
            bus_write(a, d, be, w);
            if (be[0]) begin
                if (a == 5'd0) begin m_sel = d[7:4]; m_ud = d[1]; end
                if (a == 5'd1) m_steps = d[7:0];
                if (a == 5'd2) begin
                    if (d[1]) m_done = 1'b0;
                    if (d[2]) m_err = 1'b0;
                end
            end
            ra = (i % 2 == 0) ? a : 5'($urandom_range(0, 31));
            bus_read(ra, r, w);
            check_eq("reg_rand", r, exp_reg(ra));
        end

        // Reset in the middle of a pulse.
        start_seq(8'd3, 1'b1, 4'd5);
        check_eq("pre_rst_step", 32'(bus.pll_phasestep), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_waitreq", 32'(bus.avs_s0_waitrequest), 32'h1);
        @(posedge clk); #1;
        check_eq("mid_rst_step", 32'(bus.pll_phasestep), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_clear();
        repeat (20) @(posedge clk);
        bus_read(5'd2, d, w);
        check_eq("post_rst_status", d, 32'h0);
        bus_read(5'd0, d, w);
        check_eq("post_rst_ctrl", d, exp_reg(5'd0));
        bus_read(5'd1, d, w);
        check_eq("post_rst_steps", d, exp_reg(5'd1));
        check_eq("post_rst_sel", 32'(bus.pll_phasecounterselect), 32'h0);
        check_eq("post_rst_ud", 32'(bus.pll_phaseupdown), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
